// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - loader FSM states and PROG header constants
package program_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HUNT  = 3'd0;
    localparam state_t ST_LEN   = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam int HDR_LEN = 4;

    localparam logic [7:0] MAGIC_P = 8'h50;
    localparam logic [7:0] MAGIC_R = 8'h52;
    localparam logic [7:0] MAGIC_O = 8'h4F;
    localparam logic [7:0] MAGIC_G = 8'h47;

    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return MAGIC_P;
            2'd1:    return MAGIC_R;
            2'd2:    return MAGIC_O;
            default: return MAGIC_G;
        endcase
    endfunction

endpackage

// File: rtl/program_uart_rx.sv
// rtl/program_uart_rx.sv - 8N1 receiver with synchroniser, start-bit recheck and framing-error pulse
module program_uart_rx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_dat_o,
    output logic       frame_err_o
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // [0] metastable stage, [1] synchronised line, [2] previous synchronised value
    logic [2:0]       sync_q, sync_d;
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             rx;

    assign rx = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[1:0], rx_i};
        st_d    = st_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !rx) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            default: begin
                if (cnt_q == FULL_M1) begin
                    st_d   = RX_IDLE;
                    vld_d  = rx;
                    ferr_d = ~rx;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 3'b111;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_vld_o  = vld_q;
    assign byte_dat_o  = shift_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART boot loader: PROG header hunt, length-prefixed image to memory write port
module program_loader #(
    parameter int                CLK_HZ      = 50_000_000,
    parameter int                BAUD        = 115_200,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h4000_0000,
    parameter int                TIMEOUT_CYC = 16 * (CLK_HZ / BAUD) * 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              program_rx_i,
    output logic              prog_mode_o,
    output logic              core_rst_no,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              err_o
);
    import program_loader_pkg::*;

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam logic [31:0] TMO_M1 = 32'(TIMEOUT_CYC - 1);

    logic       byte_vld, frame_err;
    logic [7:0] byte_dat;

    program_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (program_rx_i),
        .byte_vld_o  (byte_vld),
        .byte_dat_o  (byte_dat),
        .frame_err_o (frame_err)
    );

    state_t            state_q, state_d;
    logic [1:0]        match_q, match_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       word_idx_q, word_idx_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              err_q, err_d;
    logic              prog_mode_q, prog_mode_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              consume;
    logic [31:0]       asm_word;

    // The holding register is only drained in byte-consuming states; in WRITE it waits.
    assign consume  = hold_vld_q && (state_q == ST_HUNT || state_q == ST_LEN || state_q == ST_DATA);
    assign asm_word = {hold_q, shift_q[31:8]};

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        tmo_d        = '0;
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q && !consume;
        err_d        = err_q || frame_err;
        prog_mode_d  = prog_mode_q;
        core_rst_n_d = core_rst_n_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (byte_vld) begin
            hold_d     = byte_dat;
            hold_vld_d = 1'b1;
            if (hold_vld_q && !consume) err_d = 1'b1;
        end

        case (state_q)
            ST_HUNT: begin
                if (consume) begin
                    if (hold_q == magic_byte(match_q)) begin
                        if (match_q == 2'(HDR_LEN - 1)) begin
                            state_d      = ST_LEN;
                            match_d      = 2'd0;
                            byte_cnt_d   = 2'd0;
                            prog_mode_d  = 1'b1;
                            core_rst_n_d = 1'b0;
                        end else begin
                            match_d = match_q + 2'd1;
                        end
                    end else begin
                        match_d = (hold_q == MAGIC_P) ? 2'd1 : 2'd0;
                    end
                end
            end
            ST_LEN, ST_DATA: begin
                if (!byte_vld) tmo_d = tmo_q + 32'd1;
                if (consume) begin
                    shift_d    = asm_word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == ST_LEN) begin
                            len_d      = asm_word;
                            word_idx_d = '0;
                            state_d    = (asm_word == 32'd0) ? ST_DONE : ST_DATA;
                        end else begin
                            mem_valid_d = 1'b1;
                            mem_addr_d  = BASE_ADDR + ADDR_W'({word_idx_q[29:0], 2'b00});
                            mem_wdata_d = asm_word;
                            state_d     = ST_WRITE;
                        end
                    end
                end
                if (!byte_vld && tmo_q == TMO_M1) begin
                    err_d        = 1'b1;
                    state_d      = ST_HUNT;
                    prog_mode_d  = 1'b0;
                    core_rst_n_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    word_idx_d  = word_idx_q + 32'd1;
                    state_d     = (word_idx_q + 32'd1 == len_q) ? ST_DONE : ST_DATA;
                end
            end
            default: begin
                prog_mode_d  = 1'b0;
                core_rst_n_d = 1'b1;
                state_d      = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_HUNT;
            match_q      <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            tmo_q        <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            err_q        <= 1'b0;
            prog_mode_q  <= 1'b0;
            core_rst_n_q <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            tmo_q        <= tmo_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            err_q        <= err_d;
            prog_mode_q  <= prog_mode_d;
            core_rst_n_q <= core_rst_n_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign prog_mode_o = prog_mode_q;
    assign core_rst_no = core_rst_n_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a byte-stream reference model
module tb_program_loader;
    localparam int          BD   = 16;
    localparam int          TMO  = 400;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        ready_force;
    logic        rand_ready;
    logic        ready_rnd = 1'b1;
    logic        prog_mode, core_rst_n, mem_valid, err;
    logic [31:0] mem_addr, mem_wdata;
    wire         mem_ready = rand_ready ? ready_rnd : ready_force;

    always #5 clk = ~clk;

    program_loader #(
        .CLK_HZ      (BD * 115_200),
        .BAUD        (115_200),
        .ADDR_W      (32),
        .BASE_ADDR   (BASE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .program_rx_i (rx),
        .prog_mode_o  (prog_mode),
        .core_rst_no  (core_rst_n),
        .mem_valid_o  (mem_valid),
        .mem_ready_i  (mem_ready),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .err_o        (err)
    );

    int          cyc = 0;
    int          hs_cyc = 0;
    int          rise_cyc = 0;
    int          prog_cnt = 0;
    logic        core_rst_prev = 1'b1;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  stream_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        ready_rnd <= 1'($urandom_range(0, 1));
    end

    // Inputs only change just after a rising edge, so the falling edge sees the pair the next edge uses.
    always @(negedge clk) begin
        if (mem_valid && mem_ready) begin
            got_q.push_back({mem_addr, mem_wdata});
            hs_cyc <= cyc;
        end
        if (prog_mode) prog_cnt <= prog_cnt + 1;
        if (core_rst_n && !core_rst_prev) rise_cyc <= cyc;
        core_rst_prev <= core_rst_n;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BD) step();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (BD) step();
        end
        rx = stop_bit;
        repeat (BD) step();
        rx = 1'b1;
        repeat (BD) step();
    endtask

    task automatic send_stream();
        for (int i = 0; i < stream_q.size(); i++) send_byte(stream_q[i], 1'b1);
    endtask

    task automatic make_load(input int n_garbage, input int n_words);
        stream_q.delete();
        repeat (n_garbage) stream_q.push_back(8'($urandom));
        stream_q.push_back(8'h50);
        stream_q.push_back(8'h52);
        stream_q.push_back(8'h4F);
        stream_q.push_back(8'h47);
        for (int k = 0; k < 4; k++) stream_q.push_back(8'(n_words >> (8 * k)));
        repeat (4 * n_words) stream_q.push_back(8'($urandom));
    endtask

    // Reference: a 4-byte sliding window finds the header; then N, then N little-endian words.
    function automatic void build_expect();
        logic [31:0] win;
        logic [31:0] n;
        int          i;
        exp_q.delete();
        win = '0;
        i   = 0;
        while (i < stream_q.size()) begin
            win = {win[23:0], stream_q[i]};
            i++;
            if (win == 32'h5052_4F47 && i + 4 <= stream_q.size()) begin
                n = {stream_q[i+3], stream_q[i+2], stream_q[i+1], stream_q[i]};
                i += 4;
                for (int w = 0; w < int'(n) && i + 4 <= stream_q.size(); w++) begin
                    exp_q.push_back({BASE + 32'(4 * w),
                                     stream_q[i+3], stream_q[i+2], stream_q[i+1], stream_q[i]});
                    i += 4;
                end
                win = '0;
            end
        end
    endfunction

    task automatic compare_writes(input string tag, input int base);
        check_eq({tag, "_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < got_q.size(); k++)
            check_eq({tag, "_write"}, got_q[base + k], exp_q[k]);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!mem_valid && n < 3000) begin
            step();
            n++;
        end
        check_eq({tag, "_valid_seen"}, 64'(mem_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_prog_mode"}, 64'(prog_mode), 64'd0);
        check_eq({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd1);
        check_eq({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_eq({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int          base;
        int          pc0;
        logic [63:0] snap;
        logic        stable;

        rst_n       = 1'b0;
        rx          = 1'b1;
        ready_force = 1'b1;
        rand_ready  = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) step();

        // Directed two-word image
        base = got_q.size();
        stream_q = '{8'h50, 8'h52, 8'h4F, 8'h47};
        send_stream();
        check_eq("hdr_prog_mode", 64'(prog_mode), 64'd1);
        check_eq("hdr_core_rst_n", 64'(core_rst_n), 64'd0);
        stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD};
        send_stream();
        check_eq("mid_core_rst_n", 64'(core_rst_n), 64'd0);
        stream_q = '{8'hDE};
        send_stream();
        repeat (20) step();
        exp_q = '{{BASE, 32'h1234_5678}, {BASE + 32'd4, 32'hDEAD_BEEF}};
        compare_writes("directed", base);
        check_eq("release_delay", 64'(rise_cyc - hs_cyc), 64'd2);
        check_eq("directed_core_rst_n", 64'(core_rst_n), 64'd1);
        check_eq("directed_prog_mode", 64'(prog_mode), 64'd0);
        check_eq("directed_err", 64'(err), 64'd0);

        // "PPROG" with N=0
        base = got_q.size();
        pc0  = prog_cnt;
        stream_q = '{8'h50, 8'h50, 8'h52, 8'h4F, 8'h47, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream();
        repeat (20) step();
        check_eq("n0_prog_pulsed", 64'(prog_cnt > pc0), 64'd1);
        check_eq("n0_writes", 64'(got_q.size() - base), 64'd0);
        check_eq("n0_prog_mode", 64'(prog_mode), 64'd0);
        check_eq("n0_core_rst_n", 64'(core_rst_n), 64'd1);

        // Random images with garbage before the header and random ready stalls
        rand_ready = 1'b1;
        for (int it = 0; it < 5; it++) begin
            base = got_q.size();
            make_load($urandom_range(0, 3), $urandom_range(1, 3));
            build_expect();
            send_stream();
            repeat (40) step();
            compare_writes("random", base);
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        check_eq("random_err", 64'(err), 64'd0);

        // Ready held low for 50 cycles during a write
        ready_force = 1'b0;
        base = got_q.size();
        make_load(0, 1);
        build_expect();
        send_stream();
        wait_valid("stall");
        snap   = {mem_addr, mem_wdata};
        stable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (!mem_valid || {mem_addr, mem_wdata} !== snap) stable = 1'b0;
            step();
        end
        check_eq("stall_stable", 64'(stable), 64'd1);
        check_eq("stall_no_write", 64'(got_q.size() - base), 64'd0);
        ready_force = 1'b1;
        repeat (5) step();
        compare_writes("stall", base);
        check_eq("stall_valid_low", 64'(mem_valid), 64'd0);

        // Framing error inside the header
        pc0 = prog_cnt;
        send_byte(8'h50, 1'b1);
        send_byte(8'h52, 1'b1);
        send_byte(8'h4F, 1'b0);
        send_byte(8'h47, 1'b1);
        repeat (20) step();
        check_eq("ferr_err", 64'(err), 64'd1);
        check_eq("ferr_no_prog", 64'(prog_cnt - pc0), 64'd0);
        check_eq("ferr_core_rst_n", 64'(core_rst_n), 64'd1);
        rst_n = 1'b0;
        step();
        check_eq("ferr_reset_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        repeat (5) step();

        // Timeout: N=3 but only one word arrives
        base = got_q.size();
        make_load(0, 3);
        repeat (8) void'(stream_q.pop_back());
        send_stream();
        repeat (TMO - 50) step();
        check_eq("tmo_early_err", 64'(err), 64'd0);
        check_eq("tmo_early_prog", 64'(prog_mode), 64'd1);
        repeat (100) step();
        check_eq("tmo_err", 64'(err), 64'd1);
        check_eq("tmo_core_rst_n", 64'(core_rst_n), 64'd1);
        check_eq("tmo_prog_mode", 64'(prog_mode), 64'd0);
        check_eq("tmo_writes", 64'(got_q.size() - base), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();

        // Asynchronous reset while a write is pending, then a clean load
        ready_force = 1'b0;
        base = got_q.size();
        make_load(0, 1);
        send_stream();
        wait_valid("rstw");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstw");
        step();
        check_eq("rstw_writes", 64'(got_q.size() - base), 64'd0);
        rst_n       = 1'b1;
        ready_force = 1'b1;
        repeat (5) step();
        base = got_q.size();
        make_load($urandom_range(0, 2), 2);
        build_expect();
        send_stream();
        repeat (20) step();
        compare_writes("after_rst", base);
        check_eq("after_rst_core_rst_n", 64'(core_rst_n), 64'd1);
        check_eq("after_rst_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
